frame_config_loader: RTL
========================

# frame_config_loader

Configuration frame sequencer for one fabric column. It accepts a stream of 32-bit configuration words over a valid/ready handshake. Each frame's row data is assembled into the column-wide FrameData bus, and the block then fires a one-hot FrameStrobe pulse so that every tile's ConfigMem in the selected column latches the frame. It sits between the bitstream source (UART/SPI/CPU loader) and the column's FrameData/FrameStrobe inputs.

## Interface
- FrameBitsPerRow, 32: FrameData bits per tile row; equals the word width of the input stream.
- MaxFramesPerCol, 20: number of frames per column; width of FrameStrobe.
- NumRows, 4: tile rows fed per column; number of data words per frame.
- StrobeCycles, 2: length of the FrameStrobe pulse in clock cycles (≥1).

Ports:
- UserCLK  in  1  single clock; all state on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_data  in  32  configuration word.
- in_valid  in  1  word present.
- in_ready  out  1  block accepts a word this cycle (transfer = in_valid & in_ready).
- FrameData  out  FrameBitsPerRow*NumRows  assembled frame; row r is bits [32r+31:32r].
- FrameStrobe  out  MaxFramesPerCol  one-hot frame strobe.
- col_sel  out  8  column index of the current frame; valid while FrameStrobe ≠ 0.
- busy  out  1  high in any state except IDLE.
- err  out  1  sticky protocol error.
- err_clr  in  1  synchronous clear of err.
- frames_done  out  16  count of frames strobed; wraps at 16'hFFFF→0.

## Operation
- Header word: [31:16] = 16'hFAB0 (magic), [15:8] = column, [4:0] = frame index; bits [7:5] ignored.
- States:
  - IDLE
    - in_ready = 1.
    - Header with good magic and frame < MaxFramesPerCol → latch col_sel and frame, clear row counter, go to DATA.
    - Header with good magic and frame ≥ MaxFramesPerCol → set err, go to DRAIN.
    - Bad magic → set err, discard the word, stay in IDLE (resync on the next word).
  - DATA
    - in_ready = 1.
    - Each accepted word is written to row[cnt], then cnt++.
    - On the accept of word NumRows-1, go to STROBE.
  - DRAIN
    - in_ready = 1.
    - Accepts and discards NumRows words; FrameData is unchanged.
    - Then go to IDLE. No strobe is fired.
  - STROBE
    - in_ready = 0.
    - FrameStrobe[frame] = 1 for StrobeCycles cycles, then go to HOLD.
    - frames_done increments once, on entry to STROBE.
  - HOLD
    - in_ready = 0, FrameStrobe = 0, FrameData held.
    - One cycle, then go to IDLE.
- Data retention: FrameData keeps its last value after a frame completes; it is not cleared.
- Row writes: rows not yet rewritten in the current frame keep their previous contents, but are never strobed because STROBE requires all NumRows words.
- err_clr:
  - clears err next edge.
  - If err_clr and a new error occur in the same cycle, err = 1 (the set wins).
- Reset values: state IDLE, in_ready = 1, FrameData = 0, FrameStrobe = 0, col_sel = 0, busy = 0, err = 0, frames_done = 0.

## Timing
- Header accepted at edge t → busy = 1 from t+1; the first data word can be accepted at t+1.
- Last data word accepted at edge d:
  - FrameStrobe high in cycles d+1 … d+StrobeCycles.
  - HOLD in cycle d+StrobeCycles+1.
  - in_ready = 1 again in cycle d+StrobeCycles+2.
- Minimum frame period: 1 + NumRows + StrobeCycles + 1 cycles (8 with defaults).
- Stability: FrameData and col_sel are stable from cycle d+1 until the next accepted data/header word; no change occurs while FrameStrobe ≠ 0.
- All outputs are registered, except in_ready and busy, which decode state only (no dependence on in_valid).
- in_valid low in DATA/DRAIN stalls the counter with no timeout; a frame may be stretched indefinitely.
- Reset mid-operation: resetn low clears FrameStrobe asynchronously, even mid-pulse. A partial frame is lost, and the stream restarts with a header.

## Test plan
- Nominal frame:
  - Stimulus: header 32'hFAB0_0305, then words 11111111, 22222222, 33333333, 44444444 back-to-back.
  - Required: FrameData = 44444444_33333333_22222222_11111111, col_sel = 3, FrameStrobe = 20'h00020 for exactly 2 cycles, frames_done = 1, in_ready back high 8 cycles after the header.
- Backpressure and stalls:
  - Stimulus: hold in_valid high during STROBE/HOLD, and insert random in_valid gaps during DATA.
  - Required: no words are accepted while in_ready = 0, no words are lost, and the strobe fires only after the 4th data word.
- Bad magic:
  - Stimulus: 32'hDEAD_0001, then a valid header and 4 data words.
  - Required: err = 1, the first word is discarded, and the following frame strobes normally.
  - Then pulse err_clr → err = 0.
- Frame out of range:
  - Stimulus: header 32'hFAB0_0014 (frame 20) plus 4 data words.
  - Required: err = 1, FrameData unchanged, FrameStrobe stays 0, frames_done unchanged, and the block is back in IDLE after the 4 drained words.
- Reset mid-strobe:
  - Stimulus: assert resetn low during the first strobe cycle.
  - Required: FrameStrobe = 0 immediately (before the next edge), all outputs at their reset values, and the next full frame works.
- Counter wrap:
  - Stimulus: force frames_done to 16'hFFFF, then run one frame.
  - Required: frames_done = 0.

Source files
------------

// File: rtl/frame_config_loader.sv
// Configuration frame sequencer for one fabric column: assembles NumRows words
// into FrameData and fires a one-hot FrameStrobe so the column latches the frame.
module frame_config_loader #(
   parameter int FrameBitsPerRow = 32,
   parameter int MaxFramesPerCol = 20,
   parameter int NumRows         = 4,
   parameter int StrobeCycles    = 2
) (
   input  logic                                 UserCLK,
   input  logic                                 resetn,
   input  logic [FrameBitsPerRow-1:0]           in_data,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   output logic [FrameBitsPerRow*NumRows-1:0]   FrameData,
   output logic [MaxFramesPerCol-1:0]           FrameStrobe,
   output logic [7:0]                           col_sel,
   output logic                                 busy,
   output logic                                 err,
   input  logic                                 err_clr,
   output logic [15:0]                          frames_done
);

   localparam int CntW   = (NumRows > 1) ? $clog2(NumRows) : 1;
   localparam int StbW   = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
   localparam int FrameW = 5;
   localparam logic [15:0] Magic = 16'hFAB0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DATA,
      S_DRAIN,
      S_STROBE,
      S_HOLD
   } state_t;

   state_t                               state_q, state_d;
   logic [CntW-1:0]                      cnt_q, cnt_d;
   logic [StbW-1:0]                      stb_cnt_q, stb_cnt_d;
   logic [FrameW-1:0]                    frame_q, frame_d;
   logic [7:0]                           col_sel_q, col_sel_d;
   logic [FrameBitsPerRow*NumRows-1:0]   frame_data_q, frame_data_d;
   logic [MaxFramesPerCol-1:0]           frame_strobe_q, frame_strobe_d;
   logic                                 err_q, err_d;
   logic [15:0]                          frames_done_q, frames_done_d;

   logic xfer;
   logic set_err;
   logic last_row;

   // Handshake readiness depends on state only, never on in_valid.
   assign in_ready = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_DRAIN);
   assign busy     = (state_q != S_IDLE);
   assign xfer     = in_valid & in_ready;
   assign last_row = (cnt_q == CntW'(NumRows - 1));

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
      state_d        = state_q;
      cnt_d          = cnt_q;
      stb_cnt_d      = stb_cnt_q;
      frame_d        = frame_q;
      col_sel_d      = col_sel_q;
      frame_data_d   = frame_data_q;
      frame_strobe_d = frame_strobe_q;
      frames_done_d  = frames_done_q;
      set_err        = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (xfer) begin
               if (in_data[31:16] != Magic) begin
                  set_err = 1'b1;
               end else if (32'(in_data[4:0]) < MaxFramesPerCol) begin
                  col_sel_d = in_data[15:8];
                  frame_d   = in_data[4:0];
                  cnt_d     = '0;
                  state_d   = S_DATA;
               end else begin
                  set_err = 1'b1;
                  cnt_d   = '0;
                  state_d = S_DRAIN;
               end
            end
         end
         S_DATA: begin
            if (xfer) begin
               frame_data_d[cnt_q*FrameBitsPerRow +: FrameBitsPerRow] = in_data;
               if (last_row) begin
                  frame_strobe_d = {{(MaxFramesPerCol-1){1'b0}}, 1'b1} << frame_q;
                  stb_cnt_d      = '0;
                  frames_done_d  = frames_done_q + 16'd1;
                  state_d        = S_STROBE;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         S_DRAIN: begin
            if (xfer) begin
               if (last_row) state_d = S_IDLE;
               else          cnt_d   = cnt_q + CntW'(1);
            end
         end
         S_STROBE: begin
            if (stb_cnt_q == StbW'(StrobeCycles - 1)) begin
               frame_strobe_d = '0;
               state_d        = S_HOLD;
            end else begin
               stb_cnt_d = stb_cnt_q + StbW'(1);
            end
         end
         S_HOLD: begin
            state_d = S_IDLE;
         end
         default: begin
            frame_strobe_d = '0;
            state_d        = S_IDLE;
         end
      endcase

      // A new error in the same cycle as err_clr leaves err set.
      err_d = err_q;
      if (err_clr) err_d = 1'b0;
      if (set_err) err_d = 1'b1;
   end

   // NOTE: state uses non-blocking assignments so all flops update from the same pre-edge values.
   always_ff @(posedge UserCLK or negedge resetn) begin
      if (!resetn) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         stb_cnt_q      <= '0;
         frame_q        <= '0;
         col_sel_q      <= '0;
         // NOTE: FrameData is plain flops, not a RAM, so it is reset to a known zero frame.
         frame_data_q   <= '0;
         frame_strobe_q <= '0;
         err_q          <= 1'b0;
         frames_done_q  <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         stb_cnt_q      <= stb_cnt_d;
         frame_q        <= frame_d;
         col_sel_q      <= col_sel_d;
         frame_data_q   <= frame_data_d;
         frame_strobe_q <= frame_strobe_d;
         err_q          <= err_d;
         frames_done_q  <= frames_done_d;
      end
   end

   assign FrameData   = frame_data_q;
   assign FrameStrobe = frame_strobe_q;
   assign col_sel     = col_sel_q;
   assign err         = err_q;
   assign frames_done = frames_done_q;

endmodule
